// File: rtl/tof_readout_scheduler.sv
// Round-robin readout scheduler for the 8-sensor ToF comm array.
// Optional capture timestamp: define TOF_SCHED_TIMESTAMP_EN.
module tof_readout_scheduler #(
  parameter int NB_OF_SENSORS = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NB_OF_SENSORS-1:0] ready_in,
  input  logic [21:0]              data_in,
  output logic [2:0]               tof_index,
  output logic                     index_valid,
  output logic [24:0]              out_data,
  output logic [15:0]              out_ts,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    CAPTURE,
    OUTPUT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  rr_ptr;
  logic [3:0]  settle_cnt;
  logic [2:0]  grant;
  logic [2:0]  cand;
  logic        grant_en;

  assign grant_en = (state == IDLE) && enable && (|ready_in);

  // Scan downwards so the lowest offset from rr_ptr wins.
  always_comb begin
    grant = rr_ptr;
    cand  = rr_ptr;
    for (int i = NB_OF_SENSORS - 1; i >= 0; i--) begin
      cand = rr_ptr + 3'(i);
      if (ready_in[cand]) grant = cand;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant_en) state_nx = SELECT;
      SELECT:  if (settle_cnt <= 4'd1) state_nx = CAPTURE;
      CAPTURE: state_nx = OUTPUT;
      OUTPUT:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != IDLE);
    index_valid = (state == CAPTURE);
    out_valid   = (state == OUTPUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= 3'd0;
      tof_index  <= 3'd0;
      settle_cnt <= 4'd0;
      out_data   <= 25'd0;
    end else begin
      if (grant_en) begin
        tof_index  <= grant;
        settle_cnt <= 4'(SETTLE_CYCLES);
      end
      if (state == SELECT) settle_cnt <= settle_cnt - 4'd1;
      if (state == CAPTURE) begin
        out_data <= {tof_index, data_in};
        rr_ptr   <= tof_index + 3'd1;
      end
    end
  end

`ifdef TOF_SCHED_TIMESTAMP_EN
  logic [15:0] ts_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt <= 16'd0;
      out_ts <= 16'd0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
      if (state == CAPTURE) out_ts <= ts_cnt;
    end
  end
`else
  assign out_ts = 16'h0000;
`endif

endmodule

// File: tb/tb_tof_readout_scheduler.sv
// Bench for tof_readout_scheduler: comm-array emulation plus
// a transaction-level reference model of the round-robin rules.
module tb_tof_readout_scheduler;

  localparam int S = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [7:0]  flags;
  logic [21:0] data_in;
  logic [2:0]  tof_index;
  logic        index_valid;
  logic [24:0] out_data;
  logic [15:0] out_ts;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  logic [21:0] sens_data [8];

  assign data_in = sens_data[tof_index];

  always #5 clk = ~clk;

  tof_readout_scheduler #(
    .NB_OF_SENSORS(8),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .ready_in   (flags),
    .data_in    (data_in),
    .tof_index  (tof_index),
    .index_valid(index_valid),
    .out_data   (out_data),
    .out_ts     (out_ts),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  int          total = 0;
  int          bad = 0;
  bit          m_busy;
  int          m_age;
  logic [2:0]  m_grant;
  logic [2:0]  m_ptr;
  logic [24:0] m_data;
  logic [15:0] m_ts;
  int          m_edges;
  logic [7:0]  set_mask;
  logic [2:0]  dut_q [$];
  logic [24:0] held;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] rr_pick(input logic [7:0] f,
                                         input logic [2:0] p);
    logic [2:0] g;
    g = p;
    for (int i = 0; i < 8; i++) begin
      if (f[(int'(p) + i) % 8]) begin
        g = 3'((int'(p) + i) % 8);
        break;
      end
    end
    return g;
  endfunction

  task automatic step();
    if (out_valid && out_ready) dut_q.push_back(out_data[24:22]);
    if (m_busy) begin
      if (m_age == S + 1) begin
        m_data = {m_grant, sens_data[m_grant]};
        m_ts   = 16'(m_edges);
      end
      if (m_age >= S + 2 && out_ready) m_busy = 1'b0;
      else m_age++;
    end else if (enable && flags != 8'h00) begin
      m_grant = rr_pick(flags, m_ptr);
      m_ptr   = m_grant + 3'd1;
      m_busy  = 1'b1;
      m_age   = 1;
    end
    m_edges++;
    @(posedge clk);
    @(negedge clk);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("index_valid", 32'(index_valid), 32'(m_busy && m_age == S + 1));
    chk("out_valid", 32'(out_valid), 32'(m_busy && m_age >= S + 2));
    chk("tof_index", 32'(tof_index), 32'(m_grant));
    if (m_busy && m_age >= S + 2) begin
      chk("out_data", 32'(out_data), 32'(m_data));
`ifdef TOF_SCHED_TIMESTAMP_EN
      chk("out_ts", 32'(out_ts), 32'(m_ts));
`endif
    end
`ifndef TOF_SCHED_TIMESTAMP_EN
    chk("out_ts_zero", 32'(out_ts), 32'd0);
`endif
    // comm array: ack clears the flag, a new sample in the same cycle wins
    if (index_valid) flags[tof_index] = 1'b0;
    flags    = flags | set_mask;
    set_mask = 8'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_index_valid", 32'(index_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tof_index", 32'(tof_index), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ts", 32'(out_ts), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b0;
    m_busy  = 1'b0;
    m_age   = 0;
    m_grant = 3'd0;
    m_ptr   = 3'd0;
    m_edges = 0;
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    flags     = 8'h00;
    out_ready = 1'b1;
    set_mask  = 8'h00;
    m_data    = '0;
    m_ts      = '0;
    for (int i = 0; i < 8; i++) sens_data[i] = 22'($urandom);
    @(negedge clk);
    do_reset();

    // single request on sensor 2, latency 3 cycles
    enable       = 1'b1;
    sens_data[2] = 22'h0A_1234;
    flags        = 8'h04;
    repeat (3) step();
    chk("t1_latency", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'h008A_1234);
    repeat (3) step();

    // all sensors pending: strict 0..7 order then 0 again
    do_reset();
    dut_q.delete();
    flags = 8'hFF;
    repeat (32) step();
    chk("rr_count", 32'(dut_q.size()), 32'd8);
    for (int k = 0; k < 8 && k < dut_q.size(); k++)
      chk("rr_order", 32'(dut_q[k]), 32'(k));
    flags = 8'hFF;
    repeat (4) step();
    chk("rr_wrap_count", 32'(dut_q.size()), 32'd9);
    if (dut_q.size() > 8) chk("rr_wrap_first", 32'(dut_q[8]), 32'd0);
    repeat (28) step();
    flags = 8'h00;
    repeat (6) step();

    // downstream stall holds the output word
    flags     = 8'h20;
    out_ready = 1'b0;
    repeat (3) step();
    chk("stall_valid", 32'(out_valid), 32'd1);
    held = out_data;
    repeat (10) begin
      step();
      chk("stall_hold", 32'(out_data), 32'(held));
      chk("stall_no_ack", 32'(index_valid), 32'd0);
      chk("stall_index", 32'(tof_index), 32'd5);
    end
    out_ready = 1'b1;
    step();
    chk("stall_release", 32'(out_valid), 32'd0);
    chk("stall_idle", 32'(busy), 32'd0);

    // pointer wrap: 7, then 0 ahead of 7
    do_reset();
    dut_q.delete();
    flags = 8'h80;
    repeat (4) step();
    flags = 8'h81;
    repeat (8) step();
    chk("wrap_count", 32'(dut_q.size()), 32'd3);
    if (dut_q.size() == 3) begin
      chk("wrap_a", 32'(dut_q[0]), 32'd7);
      chk("wrap_b", 32'(dut_q[1]), 32'd0);
      chk("wrap_c", 32'(dut_q[2]), 32'd7);
    end

    // enable drop mid-transaction
    dut_q.delete();
    flags = 8'hFF;
    step();
    enable = 1'b0;
    repeat (20) step();
    chk("en_one_out", 32'(dut_q.size()), 32'd1);
    chk("en_idle", 32'(busy), 32'd0);
    enable = 1'b1;
    repeat (4) step();
    chk("en_resume", 32'(dut_q[dut_q.size()-1]), 32'd1);

    // reset while holding an output
    flags     = 8'h00;
    repeat (4) step();
    flags     = 8'h08;
    out_ready = 1'b0;
    repeat (3) step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    do_reset();
    out_ready = 1'b1;
    repeat (6) step();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      set_mask  = 8'($urandom & $urandom & $urandom);
      sens_data[$urandom_range(0, 7)] = 22'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
